// File: rtl/tcp_tx_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// tcp_tx_sched_pkg
// Shared types for the TCP transmit scheduler:
//   - tcp_tx_sched_state_t : scheduler FSM state encoding
//   - FLG_*                : bit positions inside a 4-bit TCP flag nibble
//   - tcp_tx_desc_t        : packed segment descriptor {flags, seq, ack}
//   - desc_legal()         : flag-combination legality check
// ---------------------------------------------------------------------------
package tcp_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } tcp_tx_sched_state_t;

    localparam int FLG_SYN = 0;
    localparam int FLG_ACK = 1;
    localparam int FLG_FIN = 2;
    localparam int FLG_RST = 3;

    typedef struct packed {
        logic [3:0]  flags;
        logic [31:0] seq;
        logic [31:0] ack;
    } tcp_tx_desc_t;

    // A descriptor is illegal when it carries no flag at all, asks to open
    // and close in the same segment, or mixes RST with anything else.
    function automatic logic desc_legal(input logic [3:0] flags);
        logic ok;
        ok = 1'b1;
        if (flags == 4'b0000) begin
            ok = 1'b0;
        end
        if (flags[FLG_SYN] && flags[FLG_FIN]) begin
            ok = 1'b0;
        end
        if (flags[FLG_RST] && (flags[FLG_SYN] || flags[FLG_ACK] || flags[FLG_FIN])) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/tcp_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// tcp_tx_sched_if
// Bundle between the segment sources, the scheduler and the transmit engine.
//   req_vld/req_rdy/req_flags/req_seq/req_ack : requester side (N_REQ slices)
//   tx_vld/tx_flags/tx_seq/tx_ack/tx_acc/tx_done : engine side
//   grant_id, tx_timeout, drop_err               : status
// Handshake: a requester holds req_vld[i] with stable data until it sees
// req_rdy[i] high in the same cycle (capture on that rising edge); it may
// drop req_vld[i] at any time before that. The engine sees tx_vld with
// stable data until it raises tx_acc; tx_done then closes the transfer.
// Modports: master = scheduler, slave = sources/engine side.
// ---------------------------------------------------------------------------
interface tcp_tx_sched_if #(
    parameter int N_REQ = 4
);
    import tcp_tx_sched_pkg::*;

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]    req_vld;
    logic [N_REQ-1:0]    req_rdy;
    logic [4*N_REQ-1:0]  req_flags;
    logic [32*N_REQ-1:0] req_seq;
    logic [32*N_REQ-1:0] req_ack;
    logic                tx_vld;
    logic [3:0]          tx_flags;
    logic [31:0]         tx_seq;
    logic [31:0]         tx_ack;
    logic                tx_acc;
    logic                tx_done;
    logic [IW-1:0]       grant_id;
    logic                tx_timeout;
    logic                drop_err;

    modport master (
        input  req_vld, req_flags, req_seq, req_ack, tx_acc, tx_done,
        output req_rdy, tx_vld, tx_flags, tx_seq, tx_ack,
        output grant_id, tx_timeout, drop_err
    );

    modport slave (
        output req_vld, req_flags, req_seq, req_ack, tx_acc, tx_done,
        input  req_rdy, tx_vld, tx_flags, tx_seq, tx_ack,
        input  grant_id, tx_timeout, drop_err
    );

endinterface

// File: rtl/tcp_tx_scheduler_arb.sv
// ---------------------------------------------------------------------------
// tcp_rr_arbiter
// Combinational winner select. Index 0 (RST source) has absolute priority;
// otherwise the first valid index at or after i_rr_ptr among 1..N_REQ-1,
// wrapping back to 1.
//   i_vld    : request vector
//   i_rr_ptr : round-robin start index (1..N_REQ-1)
//   o_any    : some request is valid
//   o_grant  : one-hot winner
//   o_idx    : winner index
// ---------------------------------------------------------------------------
module tcp_rr_arbiter
    import tcp_tx_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] i_vld,
    input  logic [IW-1:0]    i_rr_ptr,
    output logic             o_any,
    output logic [N_REQ-1:0] o_grant,
    output logic [IW-1:0]    o_idx
);

    int w_cand;

    always_comb begin
        o_any   = 1'b0;
        o_idx   = '0;
        o_grant = '0;
        w_cand  = 0;
        if (i_vld[0]) begin
            o_any = 1'b1;
        end else begin
            // Walk the shared sources starting at the pointer; the first hit wins.
            for (int k = 0; k < N_REQ - 1; k++) begin
                w_cand = ((int'(i_rr_ptr) - 1 + k) % (N_REQ - 1)) + 1;
                if (!o_any && i_vld[IW'(w_cand)]) begin
                    o_any = 1'b1;
                    o_idx = IW'(w_cand);
                end
            end
        end
        if (o_any) begin
            o_grant = N_REQ'(1) << o_idx;
        end
    end

endmodule

// File: rtl/tcp_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tcp_tx_scheduler
// Shares the single TCP transmit engine between the RST, handshake, ACK and
// FIN segment sources. Picks one descriptor, offers it to the engine, and
// holds it until tx_done or until the watchdog abandons the transfer.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : tcp_tx_sched_if.master (requesters + engine + status)
//   o_state : current FSM state, for observation
// ---------------------------------------------------------------------------
module tcp_tx_scheduler
    import tcp_tx_sched_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    tcp_tx_sched_if.master      bus,
    output tcp_tx_sched_state_t o_state
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] WD_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] WD_MAX   = CW'(TIMEOUT);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

    tcp_tx_sched_state_t r_state;
    tcp_tx_sched_state_t w_next;

    logic [IW-1:0]    r_rr_ptr;
    logic [IW-1:0]    r_gid;
    logic [CW-1:0]    r_wd;
    tcp_tx_desc_t     r_desc;
    logic             r_tx_vld;
    logic             r_timeout;

    logic             w_any;
    logic [N_REQ-1:0] w_grant;
    logic [IW-1:0]    w_idx;
    tcp_tx_desc_t     w_desc;
    logic             w_legal;
    logic             w_expired;
    logic [N_REQ-1:0] w_rdy;
    logic             w_consume;
    logic             w_capture;
    logic             w_drop;
    logic             w_timeout;

    tcp_rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .i_vld    (bus.req_vld),
        .i_rr_ptr (r_rr_ptr),
        .o_any    (w_any),
        .o_grant  (w_grant),
        .o_idx    (w_idx)
    );

    always_comb begin
        w_desc.flags = bus.req_flags[4*w_idx +: 4];
        w_desc.seq   = bus.req_seq[32*w_idx +: 32];
        w_desc.ack   = bus.req_ack[32*w_idx +: 32];
    end

    assign w_legal   = desc_legal(w_desc.flags);
    // The counter saturates at TIMEOUT, so ">=" also catches a transfer that
    // was accepted in the expiry cycle and then lingers in BUSY.
    assign w_expired = (r_wd >= WD_LAST);

    always_comb begin
        w_next    = r_state;
        w_rdy     = '0;
        w_consume = 1'b0;
        w_capture = 1'b0;
        w_drop    = 1'b0;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_rdy     = w_grant;
                    w_consume = 1'b1;
                    if (w_legal) begin
                        w_capture = 1'b1;
                        w_next    = ST_OFFER;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            ST_OFFER: begin
                if (bus.tx_acc) begin
                    w_next = ST_BUSY;
                end else if (w_expired) begin
                    w_next    = ST_IDLE;
                    w_timeout = 1'b1;
                end
            end
            ST_BUSY: begin
                if (bus.tx_done) begin
                    w_next = ST_IDLE;
                end else if (w_expired) begin
                    w_next    = ST_IDLE;
                    w_timeout = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr  <= IDX_ONE;
            r_gid     <= '0;
            r_wd      <= '0;
            r_desc    <= '0;
            r_tx_vld  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_tx_vld  <= (w_next == ST_OFFER);
            r_timeout <= w_timeout;
            // Pointer moves past any consumed shared source, legal or not;
            // RST grants leave the rotation untouched.
            if (w_consume && (w_idx != '0)) begin
                r_rr_ptr <= (w_idx == IDX_LAST) ? IDX_ONE : (w_idx + IDX_ONE);
            end
            if (w_capture) begin
                r_desc <= w_desc;
                r_gid  <= w_idx;
                r_wd   <= '0;
            end else if ((r_state != ST_IDLE) && (r_wd != WD_MAX)) begin
                r_wd <= r_wd + CW'(1);
            end
        end
    end

    // Rdy/drop are Mealy outputs; gate them so nothing is consumed in reset.
    assign bus.req_rdy    = w_rdy & {N_REQ{i_rst_n}};
    assign bus.drop_err   = w_drop & i_rst_n;
    assign bus.tx_vld     = r_tx_vld;
    assign bus.tx_flags   = r_desc.flags;
    assign bus.tx_seq     = r_desc.seq;
    assign bus.tx_ack     = r_desc.ack;
    assign bus.grant_id   = r_gid;
    assign bus.tx_timeout = r_timeout;
    assign o_state        = r_state;

endmodule

// File: tb/tb_tcp_tx_scheduler.sv
module tb_tcp_tx_scheduler;
    import tcp_tx_sched_pkg::*;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 8;
    localparam int N_RND   = 1500;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    tcp_tx_sched_state_t dut_state;

    always #5 clk = ~clk;

    tcp_tx_sched_if #(.N_REQ(N_REQ)) bus();

    tcp_tx_scheduler #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .o_state (dut_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic put_desc(input int i, input logic [3:0] f, input logic [31:0] s, input logic [31:0] a);
        bus.req_flags[4*i +: 4] = f;
        bus.req_seq[32*i +: 32] = s;
        bus.req_ack[32*i +: 32] = a;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.req_vld = '0;
        bus.tx_acc  = 1'b0;
        bus.tx_done = 1'b0;
        @(negedge clk);
        #1;
        check("rst_state",   dut_state,      ST_IDLE);
        check("rst_tx_vld",  bus.tx_vld,     0);
        check("rst_flags",   bus.tx_flags,   0);
        check("rst_seq",     bus.tx_seq,     0);
        check("rst_ack",     bus.tx_ack,     0);
        check("rst_gid",     bus.grant_id,   0);
        check("rst_timeout", bus.tx_timeout, 0);
        check("rst_rdy",     bus.req_rdy,    0);
        check("rst_drop",    bus.drop_err,   0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge while the descriptor is being offered.
    task automatic finish_xfer();
        bus.tx_acc = 1'b1;
        @(negedge clk);
        bus.tx_acc  = 1'b0;
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
    endtask

    // Called at a negedge in IDLE with req_vld held; expects exp_idx to win.
    task automatic xfer_expect(input int exp_idx);
        logic [N_REQ-1:0] exp_oh;
        exp_oh = N_REQ'(1) << exp_idx;
        #1;
        check("rr_rdy", bus.req_rdy, exp_oh);
        @(negedge clk);
        #1;
        check("rr_tx_vld", bus.tx_vld, 1);
        check("rr_gid", bus.grant_id, exp_idx);
        check("rr_rdy_offer", bus.req_rdy, 0);
        finish_xfer();
    endtask

    // ---------------- reference model ----------------
    function automatic logic ref_legal(input logic [3:0] f);
        int n;
        n = $countones(f);
        if (n == 0) return 1'b0;
        if (f[0] && f[2]) return 1'b0;
        if (f[3] && n > 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int ref_winner(input logic [N_REQ-1:0] v, input int rr);
        if (v[0]) return 0;
        for (int n = 0; n < N_REQ - 1; n++) begin
            int c;
            c = rr + n;
            if (c > N_REQ - 1) c = c - (N_REQ - 1);
            if (v[c]) return c;
        end
        return -1;
    endfunction

    typedef struct {
        int          idx;
        logic [3:0]  flags;
        logic [31:0] seq;
        logic [31:0] ack;
        logic        legal;
    } vec_t;

    vec_t vt[10];

    logic [3:0]  r_flags[N_REQ];
    logic [31:0] r_seq[N_REQ];
    logic [31:0] r_ack[N_REQ];
    logic [3:0]  legal_pick[5];

    initial begin
        int m_ph, m_age, m_rr, m_gid, w;
        logic m_vld, m_to;
        logic [3:0]  m_flags;
        logic [31:0] m_seq, m_ack;
        logic [N_REQ-1:0] exp_rdy;
        logic exp_drop;

        bus.req_vld   = '0;
        bus.req_flags = '0;
        bus.req_seq   = '0;
        bus.req_ack   = '0;
        bus.tx_acc    = 1'b0;
        bus.tx_done   = 1'b0;

        vt[0] = '{2, 4'b0011, 32'h0000_1000, 32'h0000_2000, 1'b1};
        vt[1] = '{1, 4'b0101, 32'h1111_0001, 32'h2222_0001, 1'b0};
        vt[2] = '{3, 4'b0000, 32'h1111_0002, 32'h2222_0002, 1'b0};
        vt[3] = '{0, 4'b1000, 32'hA5A5_0003, 32'h5A5A_0003, 1'b1};
        vt[4] = '{0, 4'b1001, 32'h1111_0004, 32'h2222_0004, 1'b0};
        vt[5] = '{1, 4'b0100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1};
        vt[6] = '{3, 4'b0110, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        vt[7] = '{2, 4'b1111, 32'h1111_0007, 32'h2222_0007, 1'b0};
        vt[8] = '{1, 4'b0001, 32'h1234_5678, 32'h0000_0000, 1'b1};
        vt[9] = '{2, 4'b1010, 32'h1111_0009, 32'h2222_0009, 1'b0};

        legal_pick[0] = 4'b0001;
        legal_pick[1] = 4'b0010;
        legal_pick[2] = 4'b0011;
        legal_pick[3] = 4'b0100;
        legal_pick[4] = 4'b0110;

        do_reset();

        // ---------- table-driven single descriptors ----------
        foreach (vt[v]) begin
            bus.req_vld = N_REQ'(1) << vt[v].idx;
            put_desc(vt[v].idx, vt[v].flags, vt[v].seq, vt[v].ack);
            #1;
            check("tbl_rdy",  bus.req_rdy,  N_REQ'(1) << vt[v].idx);
            check("tbl_drop", bus.drop_err, !vt[v].legal);
            @(negedge clk);
            bus.req_vld = '0;
            #1;
            check("tbl_tx_vld", bus.tx_vld, vt[v].legal);
            check("tbl_rdy_after", bus.req_rdy, 0);
            if (vt[v].legal) begin
                check("tbl_flags", bus.tx_flags, vt[v].flags);
                check("tbl_seq",   bus.tx_seq,   vt[v].seq);
                check("tbl_ack",   bus.tx_ack,   vt[v].ack);
                check("tbl_gid",   bus.grant_id, vt[v].idx);
                finish_xfer();
            end
        end

        // ---------- round robin, then RST priority ----------
        do_reset();
        put_desc(0, 4'b1000, 32'h0, 32'h0);
        for (int i = 1; i < N_REQ; i++) put_desc(i, 4'b0010, 32'(i), 32'(i));
        bus.req_vld = 4'b1110;
        xfer_expect(1);
        xfer_expect(2);
        xfer_expect(3);
        bus.req_vld = 4'b1111;
        xfer_expect(0);
        bus.req_vld = 4'b1110;
        xfer_expect(1);
        bus.req_vld = '0;

        // ---------- watchdog expiry in OFFER ----------
        bus.req_vld = 4'b0010;
        put_desc(1, 4'b0011, 32'hC0DE_0001, 32'hC0DE_1001);
        put_desc(2, 4'b0010, 32'hC0DE_0002, 32'hC0DE_1002);
        #1;
        check("to_rdy_first", bus.req_rdy, 4'b0010);
        @(negedge clk);
        bus.req_vld = 4'b0100;
        for (int k = 0; k < TIMEOUT; k++) begin
            #1;
            check("to_tx_vld_hold", bus.tx_vld, 1);
            check("to_no_pulse", bus.tx_timeout, 0);
            check("to_rdy_hold", bus.req_rdy, 0);
            @(negedge clk);
        end
        #1;
        check("to_tx_vld_drop", bus.tx_vld, 0);
        check("to_pulse", bus.tx_timeout, 1);
        check("to_state", dut_state, ST_IDLE);
        check("to_next_rdy", bus.req_rdy, 4'b0100);
        @(negedge clk);
        bus.req_vld = '0;
        #1;
        check("to_pulse_end", bus.tx_timeout, 0);
        check("to_next_vld", bus.tx_vld, 1);
        check("to_next_gid", bus.grant_id, 2);
        finish_xfer();

        // ---------- tx_done exactly at expiry ----------
        bus.req_vld = 4'b1000;
        put_desc(3, 4'b0010, 32'hBEEF_0003, 32'hBEEF_1003);
        #1;
        check("de_rdy", bus.req_rdy, 4'b1000);
        @(negedge clk);
        bus.req_vld = '0;
        bus.tx_acc  = 1'b1;
        #1;
        check("de_tx_vld", bus.tx_vld, 1);
        @(negedge clk);
        bus.tx_acc = 1'b0;
        for (int k = 2; k < TIMEOUT; k++) begin
            #1;
            check("de_busy_vld", bus.tx_vld, 0);
            check("de_busy_to", bus.tx_timeout, 0);
            @(negedge clk);
        end
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done = 1'b0;
        #1;
        check("de_no_timeout", bus.tx_timeout, 0);
        check("de_state", dut_state, ST_IDLE);
        @(negedge clk);
        #1;
        check("de_no_timeout2", bus.tx_timeout, 0);

        // ---------- reset while BUSY ----------
        bus.req_vld = 4'b1000;
        put_desc(3, 4'b0011, 32'hDEAD_0003, 32'hDEAD_1003);
        put_desc(1, 4'b0010, 32'h0BAD_0001, 32'h0BAD_1001);
        @(negedge clk);
        bus.req_vld = '0;
        bus.tx_acc  = 1'b1;
        @(negedge clk);
        bus.tx_acc = 1'b0;
        #1;
        check("mr_busy_gid", bus.grant_id, 3);
        check("mr_busy_seq", bus.tx_seq, 32'hDEAD_0003);
        bus.req_vld = 4'b0010;
        rst_n = 1'b0;
        #1;
        check("mr_tx_vld", bus.tx_vld, 0);
        check("mr_gid", bus.grant_id, 0);
        check("mr_seq", bus.tx_seq, 0);
        check("mr_flags", bus.tx_flags, 0);
        check("mr_state", dut_state, ST_IDLE);
        check("mr_rdy", bus.req_rdy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mr_rdy_release", bus.req_rdy, 4'b0010);
        @(negedge clk);
        bus.req_vld = '0;
        #1;
        check("mr_vld_after", bus.tx_vld, 1);
        check("mr_gid_after", bus.grant_id, 1);
        check("mr_seq_after", bus.tx_seq, 32'h0BAD_0001);
        finish_xfer();

        // ---------- randomized against the reference model ----------
        do_reset();
        m_ph = 0; m_age = 0; m_rr = 1; m_gid = 0;
        m_vld = 1'b0; m_to = 1'b0;
        m_flags = '0; m_seq = '0; m_ack = '0;
        for (int n = 0; n < N_RND; n++) begin
            bus.req_vld = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
            for (int i = 0; i < N_REQ; i++) begin
                if ($urandom_range(0, 9) == 0) r_flags[i] = 4'($urandom_range(0, 15));
                else if (i == 0 && $urandom_range(0, 1) == 1) r_flags[i] = 4'b1000;
                else r_flags[i] = legal_pick[$urandom_range(0, 4)];
                r_seq[i] = $urandom;
                r_ack[i] = $urandom;
                put_desc(i, r_flags[i], r_seq[i], r_ack[i]);
            end
            bus.tx_acc  = ($urandom_range(0, 3) == 0);
            bus.tx_done = ($urandom_range(0, 2) == 0);
            #1;
            w = (m_ph == 0) ? ref_winner(bus.req_vld, m_rr) : -1;
            exp_rdy  = (w >= 0) ? (N_REQ'(1) << w) : '0;
            exp_drop = (w >= 0) ? !ref_legal(r_flags[w]) : 1'b0;
            check("rnd_rdy",     bus.req_rdy,    exp_rdy);
            check("rnd_drop",    bus.drop_err,   exp_drop);
            check("rnd_tx_vld",  bus.tx_vld,     m_vld);
            check("rnd_timeout", bus.tx_timeout, m_to);
            check("rnd_gid",     bus.grant_id,   m_gid);
            check("rnd_flags",   bus.tx_flags,   m_flags);
            check("rnd_seq",     bus.tx_seq,     m_seq);
            check("rnd_ack",     bus.tx_ack,     m_ack);

            // advance the model across the coming rising edge
            m_to = 1'b0;
            case (m_ph)
                0: begin
                    if (w >= 0) begin
                        if (w != 0) m_rr = (w == N_REQ - 1) ? 1 : w + 1;
                        if (ref_legal(r_flags[w])) begin
                            m_ph = 1; m_age = 0; m_gid = w;
                            m_flags = r_flags[w]; m_seq = r_seq[w]; m_ack = r_ack[w];
                        end
                    end
                end
                1: begin
                    if (bus.tx_acc) begin
                        m_ph = 2; m_age++;
                    end else if (m_age >= TIMEOUT - 1) begin
                        m_ph = 0; m_to = 1'b1;
                    end else begin
                        m_age++;
                    end
                end
                default: begin
                    if (bus.tx_done) begin
                        m_ph = 0;
                    end else if (m_age >= TIMEOUT - 1) begin
                        m_ph = 0; m_to = 1'b1;
                    end else begin
                        m_age++;
                    end
                end
            endcase
            m_vld = (m_ph == 1);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tcp_tx_scheduler.md
# tcp_tx_scheduler

Transmit-side scheduler that shares the single TCP transmit engine between the segment sources of the TCP server: RST generation, handshake (SYN/SYN-ACK), data ACK and teardown (FIN). It picks one pending segment descriptor per transmission, hands it to the engine, and holds it until the engine reports completion or a watchdog expires. It sits between the tcp_server control/computational pair and the transmit engine.

## Interface
- N_REQ, 4, number of requesters; index 0 is the RST source, indices 1..N_REQ-1 share round-robin
- TIMEOUT, 255, watchdog limit in cycles from descriptor issue to tx_done; must be ≥ 2
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_vld  in  N_REQ  requester i has a descriptor pending
- req_rdy  out  N_REQ  one-hot pulse: descriptor i captured this cycle
- req_flags  in  4*N_REQ  per requester {RST,FIN,ACK,SYN}, bits [3:0] of slice i
- req_seq  in  32*N_REQ  per requester sequence number
- req_ack  in  32*N_REQ  per requester acknowledgement number
- tx_vld  out  1  descriptor offered to engine
- tx_flags  out  4  registered flags of offered descriptor
- tx_seq  out  32  registered sequence number
- tx_ack  out  32  registered acknowledgement number
- tx_acc  in  1  engine accepted the offered descriptor
- tx_done  in  1  engine finished transmitting
- grant_id  out  $clog2(N_REQ)  index of descriptor in flight
- tx_timeout  out  1  one-cycle pulse: watchdog expired, transfer abandoned
- drop_err  out  1  one-cycle pulse: illegal descriptor consumed and discarded

## Operation
- States: IDLE, OFFER, BUSY.
- IDLE: if any req_vld, select winner: index 0 if req_vld[0], else first valid index at or after rr_ptr among 1..N_REQ-1 (wrapping). Assert req_rdy[winner], register flags/seq/ack and grant_id.
- Illegal descriptor: flags == 0, or SYN and FIN both set, or RST with any other flag. Still consumed (req_rdy pulses), drop_err pulses same cycle, stay IDLE; rr_ptr advances as for a legal grant.
- Legal: go to OFFER. rr_ptr ← winner+1 (wraps to 1 after N_REQ-1); rr_ptr unchanged when winner is 0.
- OFFER: tx_vld = 1, outputs stable. tx_acc → BUSY. tx_done ignored in OFFER.
- BUSY: tx_vld = 0. tx_done → IDLE.
- Watchdog: wd_cnt cleared on IDLE→OFFER, increments each cycle in OFFER/BUSY; when wd_cnt == TIMEOUT-1 and no exit event that cycle → IDLE, tx_timeout pulse. Exit event (tx_acc in OFFER, tx_done in BUSY) coinciding with expiry wins; no timeout pulse.
- req_vld dropping while not granted: no effect; requester may withdraw freely before rdy.
- grant_id holds last granted index through IDLE.

## Timing
- Reset: state IDLE, rr_ptr = 1, wd_cnt = 0, req_rdy = 0, tx_vld = 0, tx_flags = 0, tx_seq = 0, tx_ack = 0, grant_id = 0, tx_timeout = 0, drop_err = 0.
- req_rdy combinational from state and req_vld (Mealy); all tx_* outputs registered.
- Capture at cycle t → tx_vld at t+1.
- Minimum descriptor period 3 cycles (IDLE, OFFER with tx_acc, BUSY with tx_done); next grant in the cycle after tx_done.
- Reset assertion mid-transfer: immediate return to reset values; in-flight descriptor lost, no pulses.
- Counter width $clog2(TIMEOUT+1); no wrap possible.

## Structure
- Package tcp_tx_sched_pkg: state enum tcp_tx_sched_state_t, flag bit positions (FLG_SYN=0, FLG_ACK=1, FLG_FIN=2, FLG_RST=3), packed descriptor struct {flags, seq, ack}, legality function.
- Sub-module tcp_rr_arbiter: combinational priority/round-robin select (vld vector, rr_ptr → one-hot grant, index); FSM, watchdog and registers in the top.

## Test plan
- Reset then req_vld[2] with flags 4'b0011, seq 0x1000, ack 0x2000 → req_rdy[2] same cycle; next cycle tx_vld=1, tx_flags=4'b0011, tx_seq=0x1000, tx_ack=0x2000, grant_id=2.
- req_vld = 4'b1110 held through three transfers → grants 1, 2, 3 in order; then raise req_vld[0] → RST granted next, rr_ptr unchanged (next non-RST grant is 1).
- Flags 4'b0101 (SYN+FIN) on req 1 → req_rdy[1] and drop_err pulse same cycle, tx_vld stays 0.
- tx_acc never asserted, TIMEOUT=8 → tx_vld high 8 cycles, tx_timeout single pulse, state IDLE, next pending request granted the following cycle.
- tx_done exactly at the expiry cycle → normal completion, tx_timeout stays 0.
- rst asserted low while in BUSY → tx_vld, grant_id, tx_seq zero immediately; after release, pending req_vld[1] granted on the first active edge.
